// File: rtl/cpu_boot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_boot_ctrl: streams an instruction image into IMEM with the MIPS core |
// | held in reset, then runs it until halt or cycle limit. BOOT_CLEAR_EN     |
// | zero-fills IMEM first. Revision: 1.0                                     |
// +--------------------------------------------------------------------------+
module cpu_boot_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  input  logic [CNT_W-1:0]  run_limit,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              trunc_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int                HOLD_W  = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                trunc_q, trunc_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
  logic [CNT_W:0]      cycle_inc;

  // One extra bit so the saturation test and the limit compare never wrap
  assign cycle_inc = {1'b0, cycle_q} + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    words_d    = words_q;
    hold_d     = '0;
    limit_d    = limit_q;
    cycle_d    = cycle_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    trunc_d    = trunc_q;
    cpu_rst_d  = cpu_rst_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          trunc_d   = 1'b0;
          cycle_d   = '0;
          words_d   = '0;
          ptr_d     = '0;
          limit_d   = run_limit;
`ifdef BOOT_CLEAR_EN
          state_d   = S_CLEAR;
`else
          state_d   = S_LOAD;
`endif
        end
      end
`ifdef BOOT_CLEAR_EN
      S_CLEAR: begin
        im_we_d    = 1'b1;
        im_addr_d  = ptr_q;
        im_wdata_d = '0;
        ptr_d      = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) state_d = S_LOAD;
      end
`endif
      S_LOAD: begin
        if (load_valid && load_ready_q) begin
          im_we_d    = 1'b1;
          im_addr_d  = ptr_q;
          im_wdata_d = load_data;
          ptr_d      = ptr_q + 1'b1;
          words_d    = words_q + 1'b1;
          if (load_last) begin
            state_d = S_HOLD;
          end else if (ptr_q == PTR_MAX) begin
            trunc_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Cycle of the last write plus RST_HOLD more cycles in reset
        if (hold_q == HOLD_W'(RST_HOLD)) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        cycle_d = cycle_inc[CNT_W] ? cycle_q : cycle_inc[CNT_W-1:0];
        if (cpu_halt) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b1;
        end else if ((limit_q != '0) && (cycle_inc == {1'b0, limit_q})) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          cpu_rst_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      words_q      <= '0;
      hold_q       <= '0;
      limit_q      <= '0;
      cycle_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      trunc_q      <= 1'b0;
      cpu_rst_q    <= 1'b1;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      words_q      <= words_d;
      hold_q       <= hold_d;
      limit_q      <= limit_d;
      cycle_q      <= cycle_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      trunc_q      <= trunc_d;
      cpu_rst_q    <= cpu_rst_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign trunc_err    = trunc_q;
  assign cycle_count  = cycle_q;
  assign words_loaded = words_q;

endmodule
`default_nettype wire
